cscv2_uart_tx: RTL
==================

Name: cscv2_uart_tx

Overview:
- Serial transmitter directly downstream of the CSCv2 CPU core.
- Consumes the core's active-low TX strobe and the A/B register outputs, assembles a byte, and shifts it out as 8N1 async serial on txd.
- Runs on its own clock; the core's strobe is treated as asynchronous.
- Holding register plus shift register: one byte can queue while another is on the wire.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per serial bit (minimum 2).
- CNT_W, 8, baud counter width; must satisfy 2**CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  block clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- tx_n  input  1  CPU TX strobe, active low; asynchronous to clk.
- aval  input  4  CPU A register; becomes byte bits [3:0].
- bval  input  4  CPU B register; becomes byte bits [7:4].
- txd  output  1  serial line, idle high.
- busy  output  1  high while a frame is on the wire or the holding register is full.
- overrun  output  1  sticky: a strobe arrived while the holding register was full.

Behaviour:
- Reset values: txd=1, busy=0, overrun=0, state IDLE, holding empty, counters 0. Reset is honoured mid-frame: txd returns to 1 immediately and the partial frame is abandoned.
- Strobe path:
  - tx_n passes through a 2-flop synchroniser (reset value 1).
  - Falling-edge detect on the synchronised value produces a 1-cycle strobe.
  - The CPU holds aval/bval stable for at least 4 clk cycles after tx_n falls.
- Capture: on a strobe, {bval,aval} loads into the holding register and hold_valid=1.
  - If hold_valid is already 1, the byte is dropped, overrun is set, and the holding contents are unchanged.
- FSM states: IDLE, START, DATA, STOP. Each bit lasts exactly CLKS_PER_BIT clk cycles.
  - IDLE -> START when hold_valid=1. On that transition the holding register moves to the shift register and hold_valid clears in the same cycle.
  - START drives txd=0, then goes to DATA.
  - DATA sends 8 bits LSB first using a 3-bit index, then goes to STOP when index wraps 7->0.
  - STOP drives txd=1, then goes to START if hold_valid, else IDLE. Back-to-back frames have no extra idle bit.
- Latency: txd falls on the 4th rising clk edge after tx_n is first sampled low, when the FSM is IDLE. A full frame is 10*CLKS_PER_BIT cycles.
- Simultaneous events:
  - A strobe in the same cycle that IDLE/STOP transfers holding to shift is accepted into the now-empty holding register, with no overrun.
  - A strobe in the same cycle reset deasserts is ignored, because the synchroniser restarts high.
- busy = (state != IDLE) | hold_valid.
- txd is driven from a flop and is glitch-free.

Optional Feature:
- CSCV2_UART_FIFO_EN.
  - Defined: the holding register becomes a 4-entry FIFO. overrun sets only when a strobe arrives with 4 bytes queued. busy = (state != IDLE) | fifo non-empty.
  - Undefined: single holding register exactly as described above.

Decomposition:
- Package cscv2_uart_pkg holds:
  - the state enum (IDLE/START/DATA/STOP);
  - DATA_BITS=8 and FRAME_BITS=10;
  - FIFO_DEPTH=4.
- One sub-module, cscv2_baud_gen. It is a CNT_W-bit down-counter reloaded with CLKS_PER_BIT-1 on a restart input. It emits a bit_done pulse when it reaches 0, and the FSM uses that pulse to advance.

Test Plan:
- CLKS_PER_BIT=4, aval=5, bval=A, pulse tx_n low 2 cycles.
  - Expect txd low at the 4th edge.
  - Expect bits 1,0,1,0,0,1,0,1 then stop 1, each 4 cycles wide.
  - busy drops 40 cycles after the start bit; overrun=0.
- Two strobes 10 cycles apart (0x12 then 0x34).
  - Expect frames back-to-back, with the stop bit of 0x12 followed immediately by the start bit of 0x34.
  - overrun=0.
- Three strobes within one frame, feature off.
  - Expect the third byte dropped and overrun=1 (sticky) after the third strobe.
  - Only 2 frames are sent.
- Same stimulus with CSCV2_UART_FIFO_EN.
  - Expect 3 frames and overrun=0.
  - A fifth strobe with 4 queued sets overrun.
- Assert reset mid-DATA bit 3.
  - Expect txd=1, busy=0 and overrun=0 asynchronously.
  - After release, a new strobe sends a clean full frame.
- Hold tx_n low 50 cycles, then high.
  - Expect exactly one frame; a level is not a repeated strobe.

Source files
------------

// File: rtl/cscv2_uart_pkg.sv
//------------------------------------------------------------------------------
// cscv2_uart_pkg : shared state encoding and framing constants for the
//                  CSCv2 UART transmitter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cscv2_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;
  localparam int FIFO_DEPTH = 4;

endpackage

`default_nettype wire

// File: rtl/cscv2_baud_gen.sv
//------------------------------------------------------------------------------
// cscv2_baud_gen : bit-period down-counter; bit_done marks the last cycle
//                  of the current serial bit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cscv2_baud_gen #(
  parameter int CLKS_PER_BIT = 104,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (restart) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign bit_done = (count == '0);

endmodule

`default_nettype wire

// File: rtl/cscv2_uart_tx.sv
//------------------------------------------------------------------------------
// cscv2_uart_tx : 8N1 transmitter fed by the CSCv2 core TX strobe and A/B regs.
//                 CSCV2_UART_FIFO_EN widens the holding register to a FIFO.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cscv2_uart_tx
  import cscv2_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_n,
  input  logic [3:0] aval,
  input  logic [3:0] bval,
  output logic       txd,
  output logic       busy,
  output logic       overrun
);

  uart_state_t          state, state_nx;
  logic [2:0]           bit_idx, idx_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic                 txd_nx;
  logic                 sync1, sync2, sync3;
  logic                 strobe, accept, drop, load, restart, bit_done;
  logic                 q_valid;
  logic [DATA_BITS-1:0] q_data;

  // sync3 only delays sync2 for the falling-edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= tx_n;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign strobe = sync3 & ~sync2;

`ifdef CSCV2_UART_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [PTR_W:0]       fifo_cnt;
  logic                 fifo_full;

  assign fifo_full = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign accept    = strobe & (~fifo_full | load);
  assign drop      = strobe & fifo_full & ~load;
  assign q_valid   = (fifo_cnt != '0);
  assign q_data    = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_mem[wr_ptr] <= {bval, aval};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (accept && !load)      fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
      else if (load && !accept) fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
    end
  end
`else
  logic                 hold_valid;
  logic [DATA_BITS-1:0] hold_data;

  // a strobe coinciding with the hand-off to the shifter finds the slot free
  assign accept  = strobe & (~hold_valid | load);
  assign drop    = strobe & hold_valid & ~load;
  assign q_valid = hold_valid;
  assign q_data  = hold_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= {bval, aval};
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun <= 1'b0;
    else if (drop) overrun <= 1'b1;
  end

  cscv2_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .bit_done(bit_done)
  );

  always_comb begin
    state_nx = state;
    idx_nx   = bit_idx;
    shift_nx = shift;
    load     = 1'b0;
    restart  = 1'b0;
    case (state)
      IDLE: begin
        if (q_valid) begin
          state_nx = START;
          shift_nx = q_data;
          load     = 1'b1;
          restart  = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_nx = DATA;
          idx_nx   = 3'd0;
          restart  = 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          idx_nx  = bit_idx + 3'd1;
          restart = 1'b1;
          if (bit_idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          restart = 1'b1;
          if (q_valid) begin
            state_nx = START;
            shift_nx = q_data;
            load     = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // line level is registered from the next state so txd never glitches
    case (state_nx)
      START:   txd_nx = 1'b0;
      DATA:    txd_nx = shift_nx[idx_nx];
      default: txd_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_idx <= 3'd0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_nx;
      bit_idx <= idx_nx;
      shift   <= shift_nx;
      txd     <= txd_nx;
    end
  end

  assign busy = (state != IDLE) | q_valid;

endmodule

`default_nettype wire
